// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: safety stage between the light controller and the lamps.
// Registers the controller's red/yellow/green request, checks one-hot encoding,
// R->G->Y->R ordering and dwell bounds, and on the first violation latches a
// fault code and flashes red until clr_fault.
// Optional build macro: TLM_FAULT_CNT_EN adds a saturating fault_count output.
module traffic_light_monitor #(
  parameter int unsigned MIN_DWELL  = 2,
  parameter int unsigned MAX_DWELL  = 16,
  parameter int unsigned FLASH_HALF = 4,
  parameter int unsigned CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       red_in,
  input  logic       yellow_in,
  input  logic       green_in,
  input  logic       clr_fault,
  output logic       lamp_red,
  output logic       lamp_yellow,
  output logic       lamp_green,
  output logic       fault,
  output logic [2:0] fault_code
`ifdef TLM_FAULT_CNT_EN
  ,
  output logic [7:0] fault_count
`endif
);

  // Phase encoding is {red, yellow, green}.
  localparam logic [2:0] PH_R = 3'b100;
  localparam logic [2:0] PH_Y = 3'b010;
  localparam logic [2:0] PH_G = 3'b001;

  localparam logic [2:0] FC_NONE   = 3'd0;
  localparam logic [2:0] FC_ONEHOT = 3'd1;
  localparam logic [2:0] FC_ORDER  = 3'd2;
  localparam logic [2:0] FC_SHORT  = 3'd3;
  localparam logic [2:0] FC_LONG   = 3'd4;

  localparam logic [CNT_W-1:0] MIN_C   = CNT_W'(MIN_DWELL);
  localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_DWELL);
  localparam logic [CNT_W-1:0] FLASH_C = CNT_W'(FLASH_HALF - 1);

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_RUN   = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  state_t           state;
  logic [2:0]       ph_q;
  logic [CNT_W-1:0] dwell_cnt;
  logic [CNT_W-1:0] flash_cnt;

  logic [2:0]       ph_in;
  logic             ph_onehot;
  logic             ph_change;
  logic [CNT_W-1:0] dwell_inc;
  logic [2:0]       viol_code;

  // Saturating increment used by the dwell counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c >= MAX_C) ? MAX_C : c + CNT_W'(1);
  endfunction

  // The only legal successor of each lit phase.
  function automatic logic [2:0] succ(input logic [2:0] ph);
    logic [2:0] n;
    case (ph)
      PH_R:    n = PH_G;
      PH_G:    n = PH_Y;
      PH_Y:    n = PH_R;
      default: n = PH_R;
    endcase
    return n;
  endfunction

  function automatic logic is_onehot(input logic [2:0] ph);
    return (ph == PH_R) || (ph == PH_Y) || (ph == PH_G);
  endfunction

  assign ph_in     = {red_in, yellow_in, green_in};
  assign ph_onehot = is_onehot(ph_in);
  assign ph_change = (ph_in != ph_q);
  assign dwell_inc = sat_inc(dwell_cnt);

  // Classify the incoming phase; checks are ordered so the lowest code wins.
  // The violating phase is judged before it is latched, so it never reaches the lamps.
  always_comb begin
    viol_code = FC_NONE;
    case (state)
      S_INIT: begin
        // A controller that never produces a valid phase is a one-hot failure.
        if (!ph_onehot && (dwell_inc >= MAX_C)) viol_code = FC_ONEHOT;
      end
      S_RUN: begin
        if (!ph_onehot)                              viol_code = FC_ONEHOT;
        else if (ph_change && (ph_in != succ(ph_q))) viol_code = FC_ORDER;
        else if (ph_change && (dwell_cnt < MIN_C))   viol_code = FC_SHORT;
        else if (!ph_change && (dwell_inc >= MAX_C)) viol_code = FC_LONG;
      end
      default: viol_code = FC_NONE;
    endcase
  end

  // Monitor FSM with registered lamp and fault outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_INIT;
      ph_q        <= '0;
      dwell_cnt   <= '0;
      flash_cnt   <= '0;
      lamp_red    <= 1'b1;
      lamp_yellow <= 1'b0;
      lamp_green  <= 1'b0;
      fault       <= 1'b0;
      fault_code  <= FC_NONE;
    end else begin
      case (state)
        S_INIT: begin
          if (ph_onehot) begin
            state                              <= S_RUN;
            ph_q                               <= ph_in;
            dwell_cnt                          <= CNT_W'(1);
            {lamp_red, lamp_yellow, lamp_green} <= ph_in;
          end else if (viol_code != FC_NONE) begin
            state       <= S_FAULT;
            fault       <= 1'b1;
            fault_code  <= viol_code;
            flash_cnt   <= '0;
            lamp_red    <= 1'b1;
            lamp_yellow <= 1'b0;
            lamp_green  <= 1'b0;
          end else begin
            // dwell_cnt doubles as the consecutive invalid-input timer here.
            dwell_cnt   <= dwell_inc;
            lamp_red    <= 1'b1;
            lamp_yellow <= 1'b0;
            lamp_green  <= 1'b0;
          end
        end
        S_RUN: begin
          if (viol_code != FC_NONE) begin
            state       <= S_FAULT;
            fault       <= 1'b1;
            fault_code  <= viol_code;
            flash_cnt   <= '0;
            lamp_red    <= 1'b1;
            lamp_yellow <= 1'b0;
            lamp_green  <= 1'b0;
          end else begin
            ph_q                               <= ph_in;
            dwell_cnt                          <= ph_change ? CNT_W'(1) : dwell_inc;
            {lamp_red, lamp_yellow, lamp_green} <= ph_in;
          end
        end
        S_FAULT: begin
          if (clr_fault) begin
            state       <= S_INIT;
            fault       <= 1'b0;
            fault_code  <= FC_NONE;
            dwell_cnt   <= '0;
            flash_cnt   <= '0;
            lamp_red    <= 1'b1;
            lamp_yellow <= 1'b0;
            lamp_green  <= 1'b0;
          end else if (flash_cnt >= FLASH_C) begin
            flash_cnt <= '0;
            lamp_red  <= ~lamp_red;
          end else begin
            flash_cnt <= flash_cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= S_INIT;
        end
      endcase
    end
  end

`ifdef TLM_FAULT_CNT_EN
  // Count every entry into FAULT; survives clr_fault, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fault_count <= '0;
    end else if ((viol_code != FC_NONE) && (fault_count != 8'hFF)) begin
      fault_count <= fault_count + 8'd1;
    end
  end
`else
  // No fault counter in this build.
`endif

endmodule
